// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx
//   Receives 11-bit PS/2 keyboard frames (start, 8 data LSB-first, odd
//   parity, stop) from raw, asynchronous kbdclk/kbddat lines.
//   Both lines are synchronised and kbdclk is deglitched before use.
//   A good byte updates o_keycode with a one-cycle o_code_valid pulse.
//   F0 and E0 prefixes are tracked and reported on the following byte.
//   Parity errors, stop errors and mid-frame stalls pulse o_frame_err.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_kbdclk       raw PS/2 clock (asynchronous)
//   i_kbddat       raw PS/2 data (asynchronous)
//   o_keycode      last good byte, held until the next good byte
//   o_code_valid   one-cycle pulse when o_keycode is updated
//   o_brk          byte was preceded by F0 (valid with o_code_valid, held)
//   o_ext          byte was preceded by E0 (valid with o_code_valid, held)
//   o_frame_err    one-cycle pulse on parity/stop error or timeout
module ps2_frame_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_kbdclk,
    input  logic       i_kbddat,
    output logic [7:0] o_keycode,
    output logic       o_code_valid,
    output logic       o_brk,
    output logic       o_ext,
    output logic       o_frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_SAT   = TW'(TIMEOUT_CYC - 1);
    // Timeout fires on the edge where the counter would reach TIMEOUT_CYC-1.
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYC - 2);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_kclk_p0, r_kclk_p1;
    logic            r_kdat_p0, r_kdat_p1;
    logic            r_clk_f;
    logic [FW-1:0]   r_filt_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic [7:0]      r_shift;
    logic [2:0]      r_bitcnt;
    logic            r_parity;
    logic            r_brk_pend;
    logic            r_ext_pend;
    logic            w_fall;
    logic            w_bit;
    logic            w_timeout;
    logic            w_frame_done;
    logic            w_good;
    logic            w_bad;

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (v == TO_SAT) ? v : v + 1'b1;
    endfunction

    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    // Fall is flagged in the cycle the filter accepts a low kbdclk, so the
    // data sample and the clk_f update share the same edge.
    assign w_fall    = r_clk_f & ~r_kclk_p1 & (r_filt_cnt == FILT_MAX);
    assign w_bit     = r_kdat_p1;
    assign w_timeout = (r_state != S_IDLE) & ~w_fall & (r_to_cnt == TO_LIMIT);
    assign w_good    = w_frame_done & w_bit & odd_parity_ok(r_shift, r_parity);
    assign w_bad     = (w_frame_done & ~w_good) | w_timeout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE:   if (w_fall && !w_bit)            w_next = S_DATA;
            S_DATA:   if (w_fall && r_bitcnt == 3'd7)  w_next = S_PARITY;
            S_PARITY: if (w_fall)                      w_next = S_STOP;
            S_STOP: begin
                if (w_fall) begin
                    w_next       = S_IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default:                                   w_next = S_IDLE;
        endcase
        if (w_timeout) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_kclk_p0    <= 1'b1;
            r_kclk_p1    <= 1'b1;
            r_kdat_p0    <= 1'b1;
            r_kdat_p1    <= 1'b1;
            r_clk_f      <= 1'b1;
            r_filt_cnt   <= '0;
            r_to_cnt     <= '0;
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_parity     <= 1'b0;
            r_brk_pend   <= 1'b0;
            r_ext_pend   <= 1'b0;
            o_keycode    <= 8'h00;
            o_code_valid <= 1'b0;
            o_brk        <= 1'b0;
            o_ext        <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            // Synchroniser stage boundary
            r_kclk_p0 <= i_kbdclk;
            r_kclk_p1 <= r_kclk_p0;
            r_kdat_p0 <= i_kbddat;
            r_kdat_p1 <= r_kdat_p0;

            // Deglitch filter: any agreement restarts the persistence count.
            if (r_kclk_p1 != r_clk_f) begin
                if (r_filt_cnt == FILT_MAX) begin
                    r_clk_f    <= r_kclk_p1;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 1'b1;
                end
            end else begin
                r_filt_cnt <= '0;
            end

            if (r_state == S_IDLE || w_fall) r_to_cnt <= '0;
            else                             r_to_cnt <= sat_inc(r_to_cnt);

            if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        r_bitcnt <= '0;
                        r_shift  <= '0;
                    end
                    S_DATA: begin
                        r_shift  <= {w_bit, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    S_PARITY: r_parity <= w_bit;
                    default: ;
                endcase
            end

            o_code_valid <= w_good;
            o_frame_err  <= w_bad;

            if (w_good) begin
                o_keycode <= r_shift;
                if (r_shift == 8'hF0) begin
                    r_brk_pend <= 1'b1;
                    o_brk      <= 1'b0;
                    o_ext      <= 1'b0;
                end else if (r_shift == 8'hE0) begin
                    r_ext_pend <= 1'b1;
                    o_brk      <= 1'b0;
                    o_ext      <= 1'b0;
                end else begin
                    o_brk      <= r_brk_pend;
                    o_ext      <= r_ext_pend;
                    r_brk_pend <= 1'b0;
                    r_ext_pend <= 1'b0;
                end
            end

            if (w_bad) begin
                r_brk_pend <= 1'b0;
                r_ext_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx
//   Directed bench for ps2_frame_rx: make/break/extended codes, parity and
//   stop errors, timeout, glitch filter and mid-frame reset.
module tb_ps2_frame_rx;

    localparam int FL = 4;
    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       kbdclk = 1'b1;
    logic       kbddat = 1'b1;
    logic [7:0] keycode;
    logic       code_valid, brk, ext, frame_err;

    int cyc = 0;
    int n_cv = 0, n_fe = 0, viol = 0;
    int cv_cyc = 0, fe_cyc = 0;
    logic prev_cv = 1'b0, prev_fe = 1'b0;
    int t_last_fall = 0;
    int n_checks = 0, n_errors = 0;

    ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_kbdclk     (kbdclk),
        .i_kbddat     (kbddat),
        .o_keycode    (keycode),
        .o_code_valid (code_valid),
        .o_brk        (brk),
        .o_ext        (ext),
        .o_frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counting and width/overlap monitoring, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (code_valid) begin
                n_cv   <= n_cv + 1;
                cv_cyc <= cyc;
            end
            if (frame_err) begin
                n_fe   <= n_fe + 1;
                fe_cyc <= cyc;
            end
            if ((code_valid && prev_cv) || (frame_err && prev_fe) ||
                (code_valid && frame_err))
                viol <= viol + 1;
            prev_cv <= code_valid;
            prev_fe <= frame_err;
        end else begin
            prev_cv <= 1'b0;
            prev_fe <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int low);
        @(negedge clk);
        kbddat = b;
        repeat (4) @(negedge clk);
        kbdclk = 1'b0;
        t_last_fall = cyc;
        repeat (low) @(negedge clk);
        kbdclk = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b0, 8);
        for (int i = 0; i < 8; i++) send_bit(d[i], 8);
        send_bit(par, 8);
        send_bit(stp, 8);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int cv0, fe0, w;
        logic [7:0] d;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_keycode", keycode, 8'h00);
        chk("rst_cv", code_valid, 1'b0);
        chk("rst_brk", brk, 1'b0);
        chk("rst_ext", ext, 1'b0);
        chk("rst_fe", frame_err, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Make code 1C
        cv0 = n_cv;
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("make_cv_cnt", n_cv - cv0, 1);
        chk("make_kc", keycode, 8'h1C);
        chk("make_brk", brk, 1'b0);
        chk("make_ext", ext, 1'b0);
        chk("make_latency", cv_cyc - t_last_fall, FL + 2);

        // Break sequence F0 1C
        send_frame(8'hF0, 1'b1, 1'b1);
        chk("f0_kc", keycode, 8'hF0);
        chk("f0_brk", brk, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("brk_cv_cnt", n_cv - cv0, 3);
        chk("brk_kc", keycode, 8'h1C);
        chk("brk_brk", brk, 1'b1);
        chk("brk_ext", ext, 1'b0);

        // Extended E0 75
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        chk("ext_kc", keycode, 8'h75);
        chk("ext_ext", ext, 1'b1);
        chk("ext_brk", brk, 1'b0);

        // Parity error
        cv0 = n_cv; fe0 = n_fe;
        send_frame(8'h1C, 1'b1, 1'b1);
        chk("par_fe_cnt", n_fe - fe0, 1);
        chk("par_cv_cnt", n_cv - cv0, 0);
        chk("par_kc", keycode, 8'h75);

        // Stop error
        fe0 = n_fe;
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("stop_fe_cnt", n_fe - fe0, 1);
        chk("stop_kc", keycode, 8'h75);

        // Error clears a pending break
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("errclr_kc", keycode, 8'h1C);
        chk("errclr_brk", brk, 1'b0);

        // Timeout after start + 4 data bits of 1C
        cv0 = n_cv; fe0 = n_fe;
        d = 8'h1C;
        send_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) send_bit(d[i], 8);
        w = 0;
        while (n_fe == fe0 && w < TO + 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        chk("to_fe_cnt", n_fe - fe0, 1);
        chk("to_latency", fe_cyc - t_last_fall, 2 + FL + TO - 1);
        chk("to_cv_cnt", n_cv - cv0, 0);
        chk("to_kc", keycode, 8'h1C);
        fe0 = n_fe;
        send_frame(8'h32, 1'b0, 1'b1);
        chk("after_to_kc", keycode, 8'h32);
        chk("after_to_fe", n_fe - fe0, 0);

        // Glitch of FL-1 cycles is ignored
        cv0 = n_cv; fe0 = n_fe;
        send_bit(1'b0, FL - 1);
        repeat (20) @(negedge clk);
        chk("glitch_cv", n_cv - cv0, 0);
        chk("glitch_fe", n_fe - fe0, 0);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("glitch_kc", keycode, 8'h1C);
        chk("glitch_frame_fe", n_fe - fe0, 0);

        // Start bit of exactly FL cycles is accepted
        cv0 = n_cv;
        d = 8'h75;
        send_bit(1'b0, FL);
        for (int i = 0; i < 8; i++) send_bit(d[i], 8);
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        repeat (4) @(negedge clk);
        chk("minlow_kc", keycode, 8'h75);
        chk("minlow_cv", n_cv - cv0, 1);

        // Reset mid-frame after 5 data bits
        fe0 = n_fe;
        d = 8'h1C;
        send_bit(1'b0, 8);
        for (int i = 0; i < 5; i++) send_bit(d[i], 8);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_kc", keycode, 8'h00);
        chk("mid_rst_cv", code_valid, 1'b0);
        chk("mid_rst_brk", brk, 1'b0);
        chk("mid_rst_ext", ext, 1'b0);
        chk("mid_rst_fe", frame_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("post_rst_kc", keycode, 8'h1C);
        chk("post_rst_fe", n_fe - fe0, 0);

        chk("pulse_rules", viol, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
